// File: rtl/demux1to4_reg.sv
// Registered 1-to-4 demultiplexer. It routes a valid/ready source word to the channel
// picked by {Sel1,Sel0}. Each channel holds its word in a one-entry output register.
module demux1to4_reg #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] In,
  input  logic             InValid,
  output logic             InReady,
  input  logic             Sel1,
  input  logic             Sel0,
  output logic [WIDTH-1:0] Out0,
  output logic [WIDTH-1:0] Out1,
  output logic [WIDTH-1:0] Out2,
  output logic [WIDTH-1:0] Out3,
  output logic             Valid0,
  output logic             Valid1,
  output logic             Valid2,
  output logic             Valid3,
  input  logic             Ready0,
  input  logic             Ready1,
  input  logic             Ready2,
  input  logic             Ready3,
  output logic [CNT_W-1:0] Cnt0,
  output logic [CNT_W-1:0] Cnt1,
  output logic [CNT_W-1:0] Cnt2,
  output logic [CNT_W-1:0] Cnt3
);

  logic [1:0]       sel;
  logic [3:0]       ready;
  logic [3:0]       push;
  logic             acc;
  logic [3:0]       valid_q, valid_d;
  logic [WIDTH-1:0] out_q [4];
  logic [WIDTH-1:0] out_d [4];
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  assign sel   = {Sel1, Sel0};
  assign ready = {Ready3, Ready2, Ready1, Ready0};

  // Only the selected channel gates the source, so a stalled channel never blocks the others.
  assign InReady = ~rst & (~valid_q[sel] | ready[sel]);
  assign acc     = InValid & InReady;

  always_comb begin
    push    = '0;
    valid_d = valid_q;
    for (int k = 0; k < 4; k++) begin
      out_d[k]   = out_q[k];
      cnt_d[k]   = cnt_q[k];
      push[k]    = acc & (sel == 2'(k));
      valid_d[k] = push[k] | (valid_q[k] & ~ready[k]);
      if (push[k]) begin
        out_d[k] = In;
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < 4; k++) begin
        out_q[k] <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < 4; k++) begin
        out_q[k] <= out_d[k];
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign Out0   = out_q[0];
  assign Out1   = out_q[1];
  assign Out2   = out_q[2];
  assign Out3   = out_q[3];
  assign Valid0 = valid_q[0];
  assign Valid1 = valid_q[1];
  assign Valid2 = valid_q[2];
  assign Valid3 = valid_q[3];
  assign Cnt0   = cnt_q[0];
  assign Cnt1   = cnt_q[1];
  assign Cnt2   = cnt_q[2];
  assign Cnt3   = cnt_q[3];

endmodule

// File: tb/tb_demux1to4_reg.sv
// Directed bench for demux1to4_reg; expected values are hand-computed constants.
module tb_demux1to4_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] In;
  logic        InValid, InReady;
  logic        Sel1, Sel0;
  logic [15:0] Out0, Out1, Out2, Out3;
  logic        Valid0, Valid1, Valid2, Valid3;
  logic        Ready0, Ready1, Ready2, Ready3;
  logic [7:0]  Cnt0, Cnt1, Cnt2, Cnt3;

  logic [15:0] outs [4];
  logic        vals [4];
  logic [7:0]  cnts [4];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux1to4_reg #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .In(In), .InValid(InValid), .InReady(InReady),
    .Sel1(Sel1), .Sel0(Sel0),
    .Out0(Out0), .Out1(Out1), .Out2(Out2), .Out3(Out3),
    .Valid0(Valid0), .Valid1(Valid1), .Valid2(Valid2), .Valid3(Valid3),
    .Ready0(Ready0), .Ready1(Ready1), .Ready2(Ready2), .Ready3(Ready3),
    .Cnt0(Cnt0), .Cnt1(Cnt1), .Cnt2(Cnt2), .Cnt3(Cnt3)
  );

  assign outs[0] = Out0;
  assign outs[1] = Out1;
  assign outs[2] = Out2;
  assign outs[3] = Out3;
  assign vals[0] = Valid0;
  assign vals[1] = Valid1;
  assign vals[2] = Valid2;
  assign vals[3] = Valid3;
  assign cnts[0] = Cnt0;
  assign cnts[1] = Cnt1;
  assign cnts[2] = Cnt2;
  assign cnts[3] = Cnt3;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input int k);
    Sel1 = k[1];
    Sel0 = k[0];
  endtask

  task automatic set_ready(input logic [3:0] r);
    {Ready3, Ready2, Ready1, Ready0} = r;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    InValid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; In = '0; InValid = 1'b0; Sel1 = 1'b0; Sel0 = 1'b0;
    set_ready(4'hF);
    #1;

    // Reset with a pending source word.
    rst = 1'b1; InValid = 1'b1; In = 16'hFFFF; set_sel(0);
    #1 chk("rst_inready_a", 16'(InReady), 16'h0);
    tick();
    chk("rst_inready_b", 16'(InReady), 16'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_valid%0d", k), 16'(vals[k]), 16'h0);
      chk($sformatf("rst_out%0d", k), outs[k], 16'h0);
      chk($sformatf("rst_cnt%0d", k), 16'(cnts[k]), 16'h0);
    end
    rst = 1'b0; InValid = 1'b0;
    tick();

    // Basic routing, one word per channel on consecutive cycles.
    set_ready(4'hF);
    for (int k = 0; k < 4; k++) begin
      In = 16'hA000 + 16'(k); set_sel(k); InValid = 1'b1;
      #1 chk($sformatf("route_inready%0d", k), 16'(InReady), 16'h1);
      tick();
      chk($sformatf("route_out%0d", k), outs[k], 16'hA000 + 16'(k));
      chk($sformatf("route_valid%0d", k), 16'(vals[k]), 16'h1);
    end
    InValid = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("route_cnt%0d", k), 16'(cnts[k]), 16'h1);
      chk($sformatf("route_drained%0d", k), 16'(vals[k]), 16'h0);
    end

    // Back-pressure on channel 2.
    do_reset();
    set_ready(4'b1011);
    In = 16'h1234; set_sel(2); InValid = 1'b1;
    tick();
    chk("bp_out2_first", Out2, 16'h1234);
    In = 16'h5678;
    #1 chk("bp_inready_stall", 16'(InReady), 16'h0);
    tick();
    chk("bp_out2_held", Out2, 16'h1234);
    chk("bp_valid2_held", 16'(Valid2), 16'h1);
    Ready2 = 1'b1;
    #1 chk("bp_inready_release", 16'(InReady), 16'h1);
    tick();
    chk("bp_out2_replaced", Out2, 16'h5678);
    chk("bp_valid2", 16'(Valid2), 16'h1);
    chk("bp_cnt2", 16'(Cnt2), 16'h2);
    InValid = 1'b0;
    tick();
    chk("bp_valid2_drained", 16'(Valid2), 16'h0);

    // Channel 1 full and stalled must not block channel 3.
    set_ready(4'b1101);
    In = 16'h1111; set_sel(1); InValid = 1'b1;
    tick();
    chk("nb_valid1", 16'(Valid1), 16'h1);
    In = 16'hBEEF;
    #1 chk("nb_inready_ch1", 16'(InReady), 16'h0);
    set_sel(3);
    #1 chk("nb_inready_ch3", 16'(InReady), 16'h1);
    tick();
    chk("nb_out3", Out3, 16'hBEEF);
    chk("nb_out1_held", Out1, 16'h1111);
    chk("nb_valid1_held", 16'(Valid1), 16'h1);
    InValid = 1'b0;
    set_ready(4'hF);
    tick();
    chk("nb_valid1_drained", 16'(Valid1), 16'h0);

    // Counter wrap on channel 0.
    do_reset();
    set_ready(4'hF);
    set_sel(0); InValid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      In = 16'(i);
      tick();
      if (i == 254) chk("wrap_cnt0_255", 16'(Cnt0), 16'd255);
    end
    chk("wrap_cnt0_0", 16'(Cnt0), 16'h0);
    chk("wrap_out0_last", Out0, 16'h00FF);
    InValid = 1'b0;
    tick();

    // Reset while channels 0 and 3 hold stalled words.
    set_ready(4'b0110);
    In = 16'hC0C0; set_sel(0); InValid = 1'b1;
    tick();
    In = 16'hC3C3; set_sel(3);
    tick();
    chk("mid_valid0_pre", 16'(Valid0), 16'h1);
    chk("mid_valid3_pre", 16'(Valid3), 16'h1);
    do_reset();
    chk("mid_valid0", 16'(Valid0), 16'h0);
    chk("mid_valid3", 16'(Valid3), 16'h0);
    chk("mid_out0", Out0, 16'h0);
    chk("mid_out3", Out3, 16'h0);
    chk("mid_cnt0", 16'(Cnt0), 16'h0);
    chk("mid_cnt3", 16'(Cnt3), 16'h0);
    set_ready(4'hF);
    In = 16'h7777; set_sel(1); InValid = 1'b1;
    tick();
    chk("post_out1", Out1, 16'h7777);
    chk("post_valid1", 16'(Valid1), 16'h1);
    chk("post_cnt1", 16'(Cnt1), 16'h1);
    InValid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
